// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one finished reservation station per cycle
// in round-robin order and registers its tag, value and destination onto the
// CDB. The station granted last cycle is masked so a slow-to-drop requester
// cannot win twice in a row.
module cdb_arbiter #(
  parameter int NUM_RS = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_RS-1:0]          req_i,
  input  logic [NUM_RS*DATA_W-1:0]   data_i,
  input  logic [NUM_RS*REG_W-1:0]    rtarget_i,
  input  logic                       hold_i,
  output logic [NUM_RS-1:0]          grant_o,
  output logic                       cdb_valid_o,
  output logic [TAG_W-1:0]           cdb_tag_o,
  output logic [DATA_W-1:0]          cdb_data_o,
  output logic [REG_W-1:0]           cdb_rtarget_o
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  if (NUM_RS < 2 || NUM_RS > 7 || NUM_RS > (1 << TAG_W) - 1) begin : g_bad_param
    $error("cdb_arbiter: NUM_RS must be 2..7 and fit in TAG_W with tag 0 reserved");
  end

  logic [NUM_RS-1:0] grant_q,   grant_d;
  logic              valid_q,   valid_d;
  logic [TAG_W-1:0]  tag_q,     tag_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [REG_W-1:0]  rtarget_q, rtarget_d;
  logic [PTR_W-1:0]  ptr_q,     ptr_d;

  logic [NUM_RS-1:0] eligible;
  logic [PTR_W:0]    scan_idx;
  logic [PTR_W-1:0]  win;
  logic              found;

  // Round-robin search: first eligible station starting at ptr, wrapping mod NUM_RS.
  always_comb begin
    eligible = req_i & ~grant_q;
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_RS)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_RS);
      end
      if (!found && eligible[scan_idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Next broadcast: Hold freezes the bus, otherwise load the winner or go idle.
  always_comb begin
    grant_d   = '0;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    rtarget_d = rtarget_q;
    ptr_d     = ptr_q;
    if (!hold_i) begin
      if (found) begin
        grant_d   = NUM_RS'(1) << win;
        valid_d   = 1'b1;
        tag_d     = TAG_W'(win) + TAG_W'(1);
        data_d    = data_i[int'(win)*DATA_W +: DATA_W];
        rtarget_d = rtarget_i[int'(win)*REG_W +: REG_W];
        ptr_d     = (win == PTR_W'(NUM_RS-1)) ? '0 : win + PTR_W'(1);
      end else begin
        valid_d = 1'b0;
        tag_d   = '0;
      end
    end
  end

  // Broadcast and pointer registers; reset discards any pending broadcast.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_q   <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
      rtarget_q <= '0;
      ptr_q     <= '0;
    end else begin
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      rtarget_q <= rtarget_d;
      ptr_q     <= ptr_d;
    end
  end

  assign grant_o       = grant_q;
  assign cdb_valid_o   = valid_q;
  assign cdb_tag_o     = tag_q;
  assign cdb_data_o    = data_q;
  assign cdb_rtarget_o = rtarget_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter (NUM_RS=4, DATA_W=16, TAG_W=3, REG_W=3).
// Each step drives inputs, pushes the expected bus state for the next cycle
// onto a scoreboard, and pops/compares it one edge later.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [11:0] rt_in;
  logic        hold;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_rt;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_RS(4), .DATA_W(16), .TAG_W(3), .REG_W(3)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .data_i       (data_in),
    .rtarget_i    (rt_in),
    .hold_i       (hold),
    .grant_o      (grant),
    .cdb_valid_o  (cdb_valid),
    .cdb_tag_o    (cdb_tag),
    .cdb_data_o   (cdb_data),
    .cdb_rtarget_o(cdb_rt)
  );

  typedef struct packed {
    logic [3:0]  g;
    logic        v;
    logic [2:0]  t;
    logic [15:0] d;
    logic [2:0]  r;
  } exp_t;

  exp_t        sb[$];
  exp_t        got, ex, e, last;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] dval[4];
  logic [2:0]  rval[4];

  always_comb begin
    data_in = '0;
    rt_in   = '0;
    for (int i = 0; i < 4; i++) begin
      data_in[i*16 +: 16] = dval[i];
      rt_in[i*3 +: 3]     = rval[i];
    end
  end

  function automatic exp_t win_exp(int i);
    exp_t x;
    x.g = 4'(1 << i);
    x.v = 1'b1;
    x.t = 3'(i + 1);
    x.d = dval[i];
    x.r = rval[i];
    return x;
  endfunction

  function automatic exp_t idle_exp(exp_t prev);
    exp_t x;
    x   = prev;
    x.g = 4'b0;
    x.v = 1'b0;
    x.t = 3'd0;
    return x;
  endfunction

  function automatic exp_t hold_exp(exp_t prev);
    exp_t x;
    x   = prev;
    x.g = 4'b0;
    return x;
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0, 1: begin rst_n = 1'b0; req = 4'b1111; e = '0; end
        2:    begin rst_n = 1'b1; req = 4'b1111; e = win_exp(0); end
        default: begin rst_n = 1'b0; req = 4'b1110; e = '0; end
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL reset step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      e = (s < 4) ? win_exp(s) : idle_exp(last);
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL round_robin step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
      req  = req & ~ex.g;
    end
  endtask

  task automatic test_ptr_wrap();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin req = 4'b0100; e = win_exp(2); end
        1: begin req = 4'b1011; e = win_exp(3); end
        2: begin req = 4'b0011; e = win_exp(0); end
        3: begin req = 4'b0010; e = win_exp(1); end
        default: begin req = 4'b0000; e = idle_exp(last); end
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL ptr_wrap step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
  endtask

  task automatic test_hold();
    dval[1] = 16'h00AB;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin hold = 1'b0; req = 4'b0010; e = win_exp(1); end
        1, 2, 3: begin hold = 1'b1; req = 4'b0001; e = hold_exp(last); end
        default: begin hold = 1'b0; req = 4'b0001; e = win_exp(0); end
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL hold step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
    dval[1] = 16'h0011;
    req = 4'b0000;
  endtask

  task automatic test_idle();
    for (int s = 0; s < 2; s++) begin
      req  = 4'b0000;
      hold = 1'b0;
      e = idle_exp(last);
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL idle step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
  endtask

  task automatic test_withdraw();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin hold = 1'b1; req = 4'b1000; e = hold_exp(last); end
        1: begin hold = 1'b0; req = 4'b0000; e = idle_exp(last); end
        2: begin hold = 1'b0; req = 4'b0100; e = win_exp(2); end
        default: begin hold = 1'b0; req = 4'b0000; e = idle_exp(last); end
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL withdraw step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 5; s++) begin
      hold = 1'b0;
      req  = (s < 4) ? 4'b0001 : 4'b0000;
      e = (s == 0 || s == 2) ? win_exp(0) : idle_exp(last);
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL back_to_back step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
  endtask

  task automatic test_reset_midflight();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin rst_n = 1'b1; req = 4'b0110; e = win_exp(1); end
        1: begin rst_n = 1'b0; req = 4'b0110; e = '0; end
        2: begin rst_n = 1'b1; req = 4'b0110; e = win_exp(1); end
        3: begin rst_n = 1'b1; req = 4'b0100; e = win_exp(2); end
        default: begin rst_n = 1'b1; req = 4'b0000; e = idle_exp(last); end
      endcase
      sb.push_back(e);
      @(posedge clk); #1;
      ex = sb.pop_front();
      got = {grant, cdb_valid, cdb_tag, cdb_data, cdb_rt};
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL reset_midflight step %0d: got g=%b v=%b tag=%0d data=%h rt=%0d, expected g=%b v=%b tag=%0d data=%h rt=%0d",
                 s, got.g, got.v, got.t, got.d, got.r, ex.g, ex.v, ex.t, ex.d, ex.r);
      end
      last = ex;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    hold  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dval[i] = 16'h0010 + 16'(i);
      rval[i] = 3'(4 + i);
    end
    last = '0;
    test_reset();
    test_round_robin();
    test_ptr_wrap();
    test_hold();
    test_idle();
    test_withdraw();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
